layer_2_argmax: RTL and testbench

Classification back-end for the Semeion accelerator. It consumes the ten registered leaky-ReLU activations of layer 2 on the stage's `done` pulse and captures them into a local bank. It then scans them sequentially, one signed compare per cycle, and reports the winning digit class (0-9), its activation value and a one-cycle `done` pulse. It sits directly after the layer-2 activation stage and is the last datapath block before the result interface.

---
 rtl/semeion_pkg.sv | 16 +
 rtl/signed_gt.sv | 12 +
 rtl/layer_2_argmax.sv | 151 +++++++++++++++
 tb/tb_layer_2_argmax.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/semeion_pkg.sv
// Shared types and constants for the Semeion classifier datapath.
package semeion_pkg;

    localparam int unsigned SIZE        = 41;
    localparam int unsigned ACT_W       = 2 * SIZE;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef logic [ACT_W-1:0] act_t;

endpackage

// File: rtl/signed_gt.sv
// Combinational two's-complement strictly-greater comparator: gt_o = (a_i > b_i).
module signed_gt #(
    parameter int unsigned W = semeion_pkg::ACT_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o
);

    assign gt_o = $signed(a_i) > $signed(b_i);

endmodule

// File: rtl/layer_2_argmax.sv
// Captures the ten layer-2 activations and scans them one signed compare per
// cycle, reporting the lowest-index maximum with a one-cycle done pulse.
module layer_2_argmax #(
    parameter int unsigned SIZE        = semeion_pkg::SIZE,
    parameter int unsigned NUM_CLASSES = semeion_pkg::NUM_CLASSES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [2*SIZE-1:0]   layer_2_act_1,
    input  logic [2*SIZE-1:0]   layer_2_act_2,
    input  logic [2*SIZE-1:0]   layer_2_act_3,
    input  logic [2*SIZE-1:0]   layer_2_act_4,
    input  logic [2*SIZE-1:0]   layer_2_act_5,
    input  logic [2*SIZE-1:0]   layer_2_act_6,
    input  logic [2*SIZE-1:0]   layer_2_act_7,
    input  logic [2*SIZE-1:0]   layer_2_act_8,
    input  logic [2*SIZE-1:0]   layer_2_act_9,
    input  logic [2*SIZE-1:0]   layer_2_act_10,
    output logic [3:0]          class_index,
    output logic [2*SIZE-1:0]   max_value,
    output logic                done,
    output logic                busy,
    output logic                overrun
);

    import semeion_pkg::*;

    localparam int unsigned AW = 2 * SIZE;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    typedef logic [AW-1:0] word_t;

    word_t             acts [NUM_CLASSES];
    word_t             bank_q [NUM_CLASSES];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    word_t             best_val_q, best_val_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [IDX_W-1:0]  cls_q, cls_d;
    word_t             max_q, max_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              capture;
    word_t             cand;
    logic              gt;

    always_comb begin
        acts[0] = layer_2_act_1;
        acts[1] = layer_2_act_2;
        acts[2] = layer_2_act_3;
        acts[3] = layer_2_act_4;
        acts[4] = layer_2_act_5;
        acts[5] = layer_2_act_6;
        acts[6] = layer_2_act_7;
        acts[7] = layer_2_act_8;
        acts[8] = layer_2_act_9;
        acts[9] = layer_2_act_10;
    end

    assign cand = bank_q[ptr_q];

    signed_gt #(.W(AW)) u_gt (
        .a_i  (cand),
        .b_i  (best_val_q),
        .gt_o (gt)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        cls_d      = cls_q;
        max_d      = max_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    best_val_d = acts[0];
                    best_idx_d = '0;
                    ptr_d      = IDX_W'(1);
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (load) overrun_d = 1'b1;
                if (gt) begin
                    best_val_d = cand;
                    best_idx_d = ptr_q;
                end
                ptr_d = ptr_q + IDX_W'(1);
                // Final compare result is forwarded straight into the output registers.
                if (ptr_q == LAST) begin
                    cls_d   = best_idx_d;
                    max_d   = best_val_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            cls_q      <= '0;
            max_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            cls_q      <= cls_d;
            max_q      <= max_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) bank_q[i] <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) bank_q[i] <= acts[i];
        end
    end

    assign class_index = cls_q;
    assign max_value   = max_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_layer_2_argmax.sv
// Directed bench for layer_2_argmax: reset, basic scan, signed/tie cases,
// overrun and back-to-back loads, with hand-computed expectations.
module tb_layer_2_argmax;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [81:0]       v [10];
    logic [3:0]        class_index;
    logic [81:0]       max_value;
    logic              done;
    logic              busy;
    logic              overrun;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    layer_2_argmax #(.SIZE(41), .NUM_CLASSES(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .layer_2_act_1  (v[0]),
        .layer_2_act_2  (v[1]),
        .layer_2_act_3  (v[2]),
        .layer_2_act_4  (v[3]),
        .layer_2_act_5  (v[4]),
        .layer_2_act_6  (v[5]),
        .layer_2_act_7  (v[6]),
        .layer_2_act_8  (v[7]),
        .layer_2_act_9  (v[8]),
        .layer_2_act_10 (v[9]),
        .class_index    (class_index),
        .max_value      (max_value),
        .done           (done),
        .busy           (busy),
        .overrun        (overrun)
    );

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [81:0] x);
        for (int i = 0; i < 10; i++) v[i] = x;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_idx"}, 82'(class_index), 82'd0);
        chk({tag, "_val"}, max_value, 82'd0);
        chk({tag, "_done"}, 82'(done), 82'd0);
        chk({tag, "_busy"}, 82'(busy), 82'd0);
        chk({tag, "_ovr"}, 82'(overrun), 82'd0);
    endtask

    // Pulses load for one edge, then waits (bounded) for done.
    task automatic classify(input string tag, input logic [3:0] exp_idx, input logic [81:0] exp_val);
        int n;
        int bcnt;
        load = 1'b1;
        step();
        load = 1'b0;
        chk({tag, "_busy0"}, 82'(busy), 82'd1);
        n = 0;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
            if (done !== 1'b1 && busy === 1'b1) bcnt++;
        end
        chk({tag, "_latency"}, 82'(n), 82'd9);
        chk({tag, "_busycycles"}, 82'(bcnt), 82'd9);
        chk({tag, "_busy_at_done"}, 82'(busy), 82'd0);
        chk({tag, "_idx"}, 82'(class_index), 82'(exp_idx));
        chk({tag, "_val"}, max_value, exp_val);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        load  = 1'b0;
        set_all('0);
        step();
        step();
        chk_zero("reset_hold");
        reset = 1'b0;
        step();

        // Basic: act_k = k*1000
        for (int k = 0; k < 10; k++) v[k] = 82'((k + 1) * 1000);
        classify("basic", 4'd9, 82'd10000);
        step();
        chk("basic_done_pulse", 82'(done), 82'd0);
        chk("basic_hold_idx", 82'(class_index), 82'd9);
        chk("basic_hold_val", max_value, 82'd10000);

        // Asynchronous reset mid-cycle
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        #2;
        reset = 1'b0;
        step();

        // Reset just before E4 aborts the scan
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("abort_busy", 82'(busy), 82'd0);
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", 82'(seen), 82'd0);
        chk("abort_busy_after", 82'(busy), 82'd0);

        // Signed and tie cases
        set_all(-82'sd5);
        v[3] = -82'sd1;
        classify("neg", 4'd3, -82'sd1);
        step();
        set_all(82'd42);
        classify("ties", 4'd0, 82'd42);
        step();
        set_all('0);
        v[6] = {1'b0, {81{1'b1}}};
        v[1] = {1'b1, {81{1'b0}}};
        classify("extremes", 4'd6, {1'b0, {81{1'b1}}});
        step();
        set_all({1'b1, {81{1'b0}}});
        v[8] = {1'b1, {80{1'b0}}, 1'b1};
        classify("mostneg", 4'd8, {1'b1, {80{1'b0}}, 1'b1});

        // Back-to-back: reload in the done cycle
        step();
        for (int k = 0; k < 10; k++) v[k] = 82'((k + 1) * 1000);
        classify("b2b_first", 4'd9, 82'd10000);
        set_all(82'd7);
        v[0] = 82'd900;
        classify("b2b_second", 4'd0, 82'd900);
        chk("b2b_overrun", 82'(overrun), 82'd0);
        step();

        // Overrun: second load 3 cycles after the first
        set_all('0);
        v[4] = 82'd500;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        set_all(82'd1000);
        v[9] = 82'd99999;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ovr_set", 82'(overrun), 82'd1);
        seen = 0;
        while (done !== 1'b1 && seen < 20) begin
            step();
            seen++;
        end
        chk("ovr_latency", 82'(seen), 82'd6);
        chk("ovr_idx", 82'(class_index), 82'd4);
        chk("ovr_val", max_value, 82'd500);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("ovr_no_second", 82'(seen), 82'd0);
        chk("ovr_hold_idx", 82'(class_index), 82'd4);
        chk("ovr_sticky", 82'(overrun), 82'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ovr_cleared", 82'(overrun), 82'd0);
        #2;
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
